// File: rtl/wm8731_init_sequencer_pkg.sv
// WM8731 register map, sequencer state encoding and the default power-up table.
// Entries beyond the table length read as zero.
package wm8731_init_sequencer_pkg;

    localparam logic [6:0] R0_LLIN   = 7'h00;
    localparam logic [6:0] R1_RLIN   = 7'h01;
    localparam logic [6:0] R2_LHP    = 7'h02;
    localparam logic [6:0] R3_RHP    = 7'h03;
    localparam logic [6:0] R4_APATH  = 7'h04;
    localparam logic [6:0] R5_DPATH  = 7'h05;
    localparam logic [6:0] R6_PWR    = 7'h06;
    localparam logic [6:0] R7_IFACE  = 7'h07;
    localparam logic [6:0] R8_SRATE  = 7'h08;
    localparam logic [6:0] R9_ACTIVE = 7'h09;
    localparam logic [6:0] R15_RESET = 7'h0F;

    typedef logic [2:0] seq_state_t;
    localparam seq_state_t ST_IDLE  = 3'd0;
    localparam seq_state_t ST_ISSUE = 3'd1;
    localparam seq_state_t ST_WAIT  = 3'd2;
    localparam seq_state_t ST_GAP   = 3'd3;
    localparam seq_state_t ST_DONE  = 3'd4;
    localparam seq_state_t ST_ERROR = 3'd5;

    typedef struct packed {
        logic [6:0] reg_addr;
        logic [8:0] reg_val;
    } cfg_entry_t;

    function automatic cfg_entry_t default_entry(input logic [3:0] idx);
        cfg_entry_t e;
        case (idx)
            4'd0:    e = {R15_RESET, 9'h000};
            4'd1:    e = {R6_PWR,    9'h010};
            4'd2:    e = {R4_APATH,  9'h012};
            4'd3:    e = {R5_DPATH,  9'h000};
            4'd4:    e = {R7_IFACE,  9'h002};
            4'd5:    e = {R8_SRATE,  9'h000};
            4'd6:    e = {R2_LHP,    9'h079};
            4'd7:    e = {R9_ACTIVE, 9'h001};
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/wm8731_init_sequencer_if.sv
// Byte-level I2C master request/completion channel.
// master = requester (sequencer), slave = the shared I2C engine.
interface wm8731_init_sequencer_if;
    logic       i2c_req;
    logic       i2c_ready;
    logic [6:0] i2c_addr;
    logic [7:0] i2c_byte0;
    logic [7:0] i2c_byte1;
    logic       i2c_done;
    logic       i2c_nack;

    modport master (
        output i2c_req, i2c_addr, i2c_byte0, i2c_byte1,
        input  i2c_ready, i2c_done, i2c_nack
    );

    modport slave (
        input  i2c_req, i2c_addr, i2c_byte0, i2c_byte1,
        output i2c_ready, i2c_done, i2c_nack
    );
endinterface

// File: rtl/wm8731_init_sequencer_rom.sv
// Config table lookup: index -> {reg_addr, reg_val}.
// Latency: combinational. Backpressure: none.
module wm8731_init_sequencer_rom
    import wm8731_init_sequencer_pkg::*;
(
    input  logic [3:0] index,
    output cfg_entry_t entry
);
    always_comb entry = default_entry(index);
endmodule

// File: rtl/wm8731_init_sequencer.sv
// Writes the codec config table through the shared I2C master with retry and settle gap.
// Latency: i2c_req rises the cycle after start; next request GAP_CYCLES+1 cycles after i2c_done.
// Backpressure: i2c_req and bytes held stable until i2c_ready.
module wm8731_init_sequencer
    import wm8731_init_sequencer_pkg::*;
#(
    parameter int         NUM_REGS       = 8,
    parameter logic [6:0] PERIPH_ADDR    = 7'h1A,
    parameter int         GAP_CYCLES     = 1000,
    parameter int         TIMEOUT_CYCLES = 65535,
    parameter int         MAX_RETRY      = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    wm8731_init_sequencer_if.master       i2c,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic [3:0]                    reg_index,
    output logic [1:0]                    retry_count
);
    localparam logic [16:0] GAP_LAST  = 17'(GAP_CYCLES - 1);
    localparam logic [16:0] TO_LAST   = 17'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  LAST_IDX  = 4'(NUM_REGS - 1);
    localparam logic [1:0]  RETRY_MAX = 2'(MAX_RETRY);

    seq_state_t  state;
    logic [16:0] cnt;
    logic [3:0]  rom_index;
    cfg_entry_t  entry;
    logic        start_ok;
    logic        accepted;
    logic        resp_ok;
    logic        resp_fail;

    assign start_ok  = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
    // Bytes are registered on the same edge that raises i2c_req, so look up the index about to be used.
    assign rom_index = start_ok ? 4'd0 : reg_index;
    assign accepted  = (state == ST_ISSUE) && i2c.i2c_req && i2c.i2c_ready;
    assign resp_ok   = (state == ST_WAIT) && i2c.i2c_done && !i2c.i2c_nack;
    // A completion pulse takes priority over a coincident timeout.
    assign resp_fail = (state == ST_WAIT) &&
                       ((i2c.i2c_done && i2c.i2c_nack) || (!i2c.i2c_done && cnt == TO_LAST));

    wm8731_init_sequencer_rom u_rom (
        .index (rom_index),
        .entry (entry)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            reg_index     <= '0;
            retry_count   <= '0;
            i2c.i2c_req   <= 1'b0;
            i2c.i2c_addr  <= '0;
            i2c.i2c_byte0 <= '0;
            i2c.i2c_byte1 <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start_ok) begin
                        state         <= ST_ISSUE;
                        reg_index     <= '0;
                        retry_count   <= '0;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        error         <= 1'b0;
                        i2c.i2c_req   <= 1'b1;
                        i2c.i2c_addr  <= PERIPH_ADDR;
                        i2c.i2c_byte0 <= {entry.reg_addr, entry.reg_val[8]};
                        i2c.i2c_byte1 <= entry.reg_val[7:0];
                    end
                end
                ST_ISSUE: begin
                    if (accepted) begin
                        state       <= ST_WAIT;
                        i2c.i2c_req <= 1'b0;
                        cnt         <= '0;
                    end
                end
                ST_WAIT: begin
                    if (resp_ok) begin
                        if (reg_index == LAST_IDX) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state       <= ST_GAP;
                            reg_index   <= reg_index + 4'd1;
                            retry_count <= '0;
                            cnt         <= '0;
                        end
                    end else if (resp_fail) begin
                        if (retry_count < RETRY_MAX) begin
                            state       <= ST_GAP;
                            retry_count <= retry_count + 2'd1;
                            cnt         <= '0;
                        end else begin
                            state <= ST_ERROR;
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 17'd1;
                    end
                end
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        state         <= ST_ISSUE;
                        i2c.i2c_req   <= 1'b1;
                        i2c.i2c_addr  <= PERIPH_ADDR;
                        i2c.i2c_byte0 <= {entry.reg_addr, entry.reg_val[8]};
                        i2c.i2c_byte1 <= entry.reg_val[7:0];
                    end else begin
                        cnt <= cnt + 17'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wm8731_init_sequencer.sv
// Scoreboarded bench: stimulus pushes expected transactions, a monitor checks each accepted request.
module tb_wm8731_init_sequencer;
    localparam int GAP  = 4;
    localparam int TOUT = 20;
    localparam int MAXR = 3;
    localparam int NREG = 8;

    typedef struct {
        int idx;
        int retry;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       busy, done, error;
    logic [3:0] reg_index;
    logic [1:0] retry_count;

    wm8731_init_sequencer_if ifc ();

    wm8731_init_sequencer #(
        .NUM_REGS       (NREG),
        .PERIPH_ADDR    (7'h1A),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TOUT),
        .MAX_RETRY      (MAXR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .i2c         (ifc.master),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .reg_index   (reg_index),
        .retry_count (retry_count)
    );

    always #5 clk = ~clk;

    // Hand-packed bytes of the default table.
    logic [7:0] exp_b0 [NREG] = '{8'h1E, 8'h0C, 8'h08, 8'h0A, 8'h0E, 8'h10, 8'h04, 8'h12};
    logic [7:0] exp_b1 [NREG] = '{8'h00, 8'h10, 8'h12, 8'h00, 8'h02, 8'h00, 8'h79, 8'h01};

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   nack_idx = -1, nack_times = 0, silent_idx = -1, bp_cycles = 0;
    int   m_idx = 0, m_att = 0;
    bit   to_check = 1'b0;
    int   last_acc = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input int idx, input int retry);
        exp_t e;
        e.idx   = idx;
        e.retry = retry;
        sbq.push_back(e);
    endtask

    task automatic setup(input int n_idx, input int n_times, input int s_idx, input int bp, input bit to);
        nack_idx = n_idx; nack_times = n_times; silent_idx = s_idx; bp_cycles = bp;
        to_check = to; last_acc = -1; m_idx = 0; m_att = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("start_latency_req", 32'(ifc.i2c_req), 32'd1);
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_clears_flags", 32'({done, error}), 32'd0);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 3000) begin @(negedge clk); n++; end
        if (busy) begin
            checks++; failures++;
            $display("FAIL %s_wait_idle actual=busy required=idle", name);
        end
        repeat (30) @(negedge clk);
        chk({name, "_sb_drained"}, 32'(sbq.size()), 32'd0);
    endtask

    task automatic chk_end(input string name, input bit e_done, input bit e_err, input int e_idx, input int e_retry);
        chk({name, "_done"},  32'(done), 32'(e_done));
        chk({name, "_error"}, 32'(error), 32'(e_err));
        chk({name, "_busy"},  32'(busy), 32'd0);
        chk({name, "_index"}, 32'(reg_index), 32'(e_idx));
        chk({name, "_retry"}, 32'(retry_count), 32'(e_retry));
    endtask

    task automatic chk_reset_outputs();
        chk("rst_status", 32'({busy, done, error, reg_index, retry_count}), 32'd0);
        chk("rst_req", 32'(ifc.i2c_req), 32'd0);
        chk("rst_addr_bytes", 32'({ifc.i2c_addr, ifc.i2c_byte0, ifc.i2c_byte1}), 32'd0);
    endtask

    initial forever begin @(posedge clk); cyc++; end

    // Monitor: a request seen with ready at the negedge is accepted on the next posedge.
    initial begin : monitor
        bit         prev_req = 1'b0;
        logic [7:0] pb0 = '0, pb1 = '0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_req = 1'b0;
            end else begin
                if (ifc.i2c_req && prev_req)
                    chk("bytes_stable", 32'({ifc.i2c_byte0, ifc.i2c_byte1}), 32'({pb0, pb1}));
                if (ifc.i2c_req && ifc.i2c_ready) begin
                    if (sbq.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_req actual=index%0d required=none", reg_index);
                    end else begin
                        e = sbq.pop_front();
                        chk("req_addr",  32'(ifc.i2c_addr), 32'h1A);
                        chk("req_byte0", 32'(ifc.i2c_byte0), 32'(exp_b0[e.idx]));
                        chk("req_byte1", 32'(ifc.i2c_byte1), 32'(exp_b1[e.idx]));
                        chk("req_index", 32'(reg_index), 32'(e.idx));
                        chk("req_retry", 32'(retry_count), 32'(e.retry));
                    end
                    if (to_check && last_acc >= 0)
                        chk("timeout_reissue_interval", 32'(cyc - last_acc), 32'(TOUT + GAP + 1));
                    last_acc = cyc;
                end
                prev_req = ifc.i2c_req;
                pb0 = ifc.i2c_byte0;
                pb1 = ifc.i2c_byte1;
            end
        end
    end

    // I2C master model: accepts requests, answers 3 cycles later per the NACK/silent plan.
    initial begin : responder
        int n;
        bit nk;
        bit more;
        ifc.i2c_ready = 1'b0; ifc.i2c_done = 1'b0; ifc.i2c_nack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (ifc.i2c_req && !reset) begin
                if (bp_cycles > 0) begin
                    repeat (bp_cycles) begin @(posedge clk); #1; end
                    bp_cycles = 0;
                    chk("bp_req_held", 32'(ifc.i2c_req), 32'd1);
                end
                ifc.i2c_ready = 1'b1;
                @(posedge clk); #1;
                ifc.i2c_ready = 1'b0;
                if (m_idx == silent_idx) begin
                    m_att++;
                    continue;
                end
                nk = (m_idx == nack_idx) && (m_att < nack_times);
                repeat (3) begin @(posedge clk); #1; end
                ifc.i2c_done = 1'b1; ifc.i2c_nack = nk;
                @(posedge clk); #1;
                ifc.i2c_done = 1'b0; ifc.i2c_nack = 1'b0;
                if (nk) m_att++;
                else begin m_idx++; m_att = 0; end
                more = nk ? (m_att <= MAXR) : (m_idx < NREG);
                if (more) begin
                    n = 1;
                    while (!ifc.i2c_req && n < 100) begin @(posedge clk); #1; n++; end
                    chk("gap_done_to_req", 32'(n), 32'(GAP + 1));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        reset = 1'b1; start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs();
        @(posedge clk); #1 reset = 1'b0;

        // Happy path.
        setup(-1, 0, -1, 0, 1'b0);
        for (int i = 0; i < NREG; i++) push(i, 0);
        pulse_start();
        wait_idle("happy");
        chk_end("happy", 1'b1, 1'b0, NREG - 1, 0);

        // Backpressure on the first request.
        setup(-1, 0, -1, 10, 1'b0);
        for (int i = 0; i < NREG; i++) push(i, 0);
        pulse_start();
        wait_idle("bp");
        chk_end("bp", 1'b1, 1'b0, NREG - 1, 0);

        // Entry 2 NACKed twice, then accepted.
        setup(2, 2, -1, 0, 1'b0);
        push(0, 0); push(1, 0);
        for (int r = 0; r < 3; r++) push(2, r);
        for (int i = 3; i < NREG; i++) push(i, 0);
        pulse_start();
        wait_idle("nack");
        chk_end("nack", 1'b1, 1'b0, NREG - 1, 0);

        // Entry 5 always NACKed: retries exhausted.
        setup(5, 99, -1, 0, 1'b0);
        for (int i = 0; i < 5; i++) push(i, 0);
        for (int r = 0; r <= MAXR; r++) push(5, r);
        pulse_start();
        wait_idle("exhaust");
        chk_end("exhaust", 1'b0, 1'b1, 5, MAXR);

        // No completion ever: timeouts on entry 0.
        setup(-1, 0, 0, 0, 1'b1);
        for (int r = 0; r <= MAXR; r++) push(0, r);
        pulse_start();
        wait_idle("timeout");
        chk_end("timeout", 1'b0, 1'b1, 0, MAXR);

        // Reset while waiting on entry 3, then restart from entry 0.
        setup(-1, 0, 3, 0, 1'b0);
        for (int i = 0; i < 4; i++) push(i, 0);
        pulse_start();
        n = 0;
        while (sbq.size() != 0 && n < 500) begin @(negedge clk); n++; end
        chk("rst_test_reached_entry3", 32'(sbq.size()), 32'd0);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs();
        @(posedge clk); #1 reset = 1'b0;
        setup(-1, 0, -1, 0, 1'b0);
        for (int i = 0; i < NREG; i++) push(i, 0);
        pulse_start();
        wait_idle("restart");
        chk_end("restart", 1'b1, 1'b0, NREG - 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
